// File: rtl/ps2_key_tracker.sv
// PS/2 make/break tracker for N_KEYS configurable scancodes, republishing the held-key bitmap on a divided tick.
// Build option: define KEY_EXT_EN so that E0-prefixed sequences never match a tracked key.

module ps2_key_slot #(
  parameter logic [7:0] CODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code,
  input  logic       make_en,
  input  logic       brk_en,
  output logic       held
);
  logic hit;
  assign hit = (code == CODE);

  always_ff @(posedge clk) begin
    if (!rst_n)              held <= 1'b0;
    else if (make_en && hit) held <= 1'b1;
    else if (brk_en && hit)  held <= 1'b0;
  end
endmodule

module ps2_key_tracker #(
  parameter int                  N_KEYS    = 4,
  parameter logic [N_KEYS*8-1:0] KEY_CODES = {8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter int                  DIV       = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        code_i,
  input  logic              code_valid_i,
  output logic [N_KEYS-1:0] code_o,
  output logic              tick_o,
  output logic              changed_o
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
`ifdef KEY_EXT_EN
  localparam logic EXT_MATCH = 1'b0;
`else
  localparam logic EXT_MATCH = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} st_t;

  st_t               st, st_nxt;
  logic              make_en, brk_en;
  logic [N_KEYS-1:0] key_state;
  logic [CW-1:0]     cnt;
  logic              tick;

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt  = st;
    make_en = 1'b0;
    brk_en  = 1'b0;
    if (code_valid_i) begin
      unique case (st)
        IDLE: begin
          if (code_i == 8'hF0)      st_nxt = BRK;
          else if (code_i == 8'hE0) st_nxt = EXT;
          else                      make_en = 1'b1;
        end
        BRK: begin
          if (code_i == 8'hE0)      st_nxt = EXT_BRK;
          else if (code_i != 8'hF0) begin
            brk_en = 1'b1;
            st_nxt = IDLE;
          end
        end
        EXT: begin
          if (code_i == 8'hF0)      st_nxt = EXT_BRK;
          else if (code_i != 8'hE0) begin
            make_en = EXT_MATCH;
            st_nxt  = IDLE;
          end
        end
        EXT_BRK: begin
          if (code_i != 8'hF0 && code_i != 8'hE0) begin
            brk_en = EXT_MATCH;
            st_nxt = IDLE;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  // One slot per tracked key; duplicate codes simply update together.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    ps2_key_slot #(.CODE(KEY_CODES[8*i +: 8])) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .code    (code_i),
      .make_en (make_en),
      .brk_en  (brk_en),
      .held    (key_state[i])
    );
  end

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // Snapshot uses pre-edge key_state, so a byte landing on the tick edge waits a period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_o    <= '0;
      tick_o    <= 1'b0;
      changed_o <= 1'b0;
    end else begin
      tick_o    <= tick;
      changed_o <= tick && (key_state != code_o);
      if (tick) code_o <= key_state;
    end
  end
endmodule
